trig_seq: RTL

- Parametrised multi-stage trigger sequencer for the logic analyser capture path; generalises the fixed 8-level trigger to N stages.
- Adds per-stage occurrence counts, AND/OR combine mode, edge qualification and a post-trigger counter.
- Sits between the sampler and the sample FIFO.
- Tags the sample stream with trigger and last markers.
- Configuration comes from the AXI-MM register block.

---
 rtl/logicap_pkg.sv | 22 ++
 rtl/trig_stage_match.sv | 46 ++++
 rtl/trig_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logicap_pkg.sv
// Shared types and encodings for the logic analyser trigger path.
//   state_e     : trigger sequencer state
//   TRIG_LEVEL  : per-bit type, match on level
//   TRIG_EDGE   : per-bit type, match on a transition into the required level
//   CMB_AND     : stage combine, all masked bits must match
//   CMB_ANY     : stage combine, any masked bit may match
package logicap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

    localparam logic CMB_AND = 1'b0;
    localparam logic CMB_ANY = 1'b1;

endpackage

// File: rtl/trig_stage_match.sv
// Combinational match of one trigger stage against the current sample.
//   din, prev, prev_valid : current sample, previous sample and its validity
//   mask                  : bits that take part in the match
//   trig_type             : per bit, level or edge qualification
//   level                 : per bit, required level or edge direction
//   any                   : combine mode, all masked bits or any masked bit
//   match                 : stage condition satisfied (always 1 for empty mask)
module trig_stage_match
    import logicap_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0] din,
    input  logic [size-1:0] prev,
    input  logic            prev_valid,
    input  logic [size-1:0] mask,
    input  logic [size-1:0] trig_type,
    input  logic [size-1:0] level,
    input  logic            any,
    output logic            match
);

    logic [size-1:0] bit_match;

    always_comb begin
        bit_match = '0;
        for (int b = 0; b < size; b++) begin
            if (trig_type[b] == TRIG_EDGE) begin
                bit_match[b] = prev_valid && (prev[b] != din[b]) && (din[b] == level[b]);
            end else begin
                bit_match[b] = (din[b] == level[b]);
            end
        end
    end

    always_comb begin
        if (mask == '0) begin
            match = 1'b1;
        end else if (any == CMB_ANY) begin
            match = |(bit_match & mask);
        end else begin
            match = &(bit_match | ~mask);
        end
    end

endmodule

// File: rtl/trig_seq.sv
// Multi-stage trigger sequencer between the sampler and the sample FIFO.
// Walks through up to num_stages match conditions (each with an occurrence
// count), then passes post-trigger samples until the post count is exhausted.
// Samples seen while ARMED or POST are forwarded one cycle later, tagged with
// trigger and last markers.
//   clk, reset          : clock, synchronous active-high reset
//   din, din_valid      : sample stream in
//   arm, abort          : start / cancel a capture sequence
//   cfg_*               : stage and sequence configuration, latched on arm
//   armed, triggered,
//   done, stage         : sequence status
//   dout*               : registered, tagged sample stream out
//
//   state | meaning
//   IDLE  | waiting for arm, nothing emitted
//   ARMED | evaluating stages, samples forwarded
//   POST  | trigger seen, counting post-trigger samples
//   DONE  | capture complete, waiting for re-arm
module trig_seq
    import logicap_pkg::*;
#(
    parameter int size       = 32,
    parameter int num_stages = 8,
    parameter int cnt_w      = 16,
    parameter int saddr_w    = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [size-1:0]               din,
    input  logic                          din_valid,
    input  logic                          arm,
    input  logic                          abort,
    input  logic [num_stages*size-1:0]    cfg_mask,
    input  logic [num_stages*size-1:0]    cfg_type,
    input  logic [num_stages*size-1:0]    cfg_level,
    input  logic [num_stages-1:0]         cfg_any,
    input  logic [num_stages*cnt_w-1:0]   cfg_count,
    input  logic [$clog2(num_stages)-1:0] cfg_last_stage,
    input  logic [saddr_w-1:0]            cfg_post_count,
    output logic                          armed,
    output logic                          triggered,
    output logic                          done,
    output logic [$clog2(num_stages)-1:0] stage,
    output logic [size-1:0]               dout,
    output logic                          dout_valid,
    output logic                          dout_trig,
    output logic                          dout_last
);

    localparam int SW = $clog2(num_stages);
    localparam logic [SW-1:0] LAST_MAX = SW'(num_stages - 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [SW-1:0]     last_q, last_d;
    logic [cnt_w-1:0]  occ_q, occ_d;
    logic [saddr_w-1:0] rem_q, rem_d;
    logic [saddr_w-1:0] post_q, post_d;
    logic [size-1:0]   prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              triggered_q, triggered_d;
    logic [size-1:0]   dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_trig_q, dout_trig_d;
    logic              dout_last_q, dout_last_d;

    logic [size-1:0]   mask_q [num_stages];
    logic [size-1:0]   mask_d [num_stages];
    logic [size-1:0]   type_q [num_stages];
    logic [size-1:0]   type_d [num_stages];
    logic [size-1:0]   level_q [num_stages];
    logic [size-1:0]   level_d [num_stages];
    logic [cnt_w-1:0]  count_q [num_stages];
    logic [cnt_w-1:0]  count_d [num_stages];
    logic [num_stages-1:0] any_q, any_d;

    logic [SW-1:0]     last_clamped;
    logic              stage_match;

    // With a power-of-two stage count every encodable index is legal.
    if ((1 << SW) == num_stages) begin : g_no_clamp
        assign last_clamped = cfg_last_stage;
    end else begin : g_clamp
        assign last_clamped = (cfg_last_stage > LAST_MAX) ? LAST_MAX : cfg_last_stage;
    end

    trig_stage_match #(.size(size)) u_match (
        .din        (din),
        .prev       (prev_q),
        .prev_valid (prev_valid_q),
        .mask       (mask_q[stage_q]),
        .trig_type  (type_q[stage_q]),
        .level      (level_q[stage_q]),
        .any        (any_q[stage_q]),
        .match      (stage_match)
    );

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        last_d       = last_q;
        occ_d        = occ_q;
        rem_d        = rem_q;
        post_d       = post_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        triggered_d  = triggered_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_trig_d  = 1'b0;
        dout_last_d  = 1'b0;
        mask_d       = mask_q;
        type_d       = type_q;
        level_d      = level_q;
        count_d      = count_q;
        any_d        = any_q;

        if (abort) begin
            state_d      = ST_IDLE;
            stage_d      = '0;
            occ_d        = '0;
            rem_d        = '0;
            prev_valid_d = 1'b0;
            triggered_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        for (int s = 0; s < num_stages; s++) begin
                            mask_d[s]  = cfg_mask[s*size +: size];
                            type_d[s]  = cfg_type[s*size +: size];
                            level_d[s] = cfg_level[s*size +: size];
                            count_d[s] = cfg_count[s*cnt_w +: cnt_w];
                        end
                        any_d        = cfg_any;
                        last_d       = last_clamped;
                        post_d       = cfg_post_count;
                        stage_d      = '0;
                        occ_d        = '0;
                        rem_d        = '0;
                        prev_valid_d = 1'b0;
                        triggered_d  = 1'b0;
                        state_d      = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (din_valid) begin
                        dout_d       = din;
                        dout_valid_d = 1'b1;
                        prev_d       = din;
                        prev_valid_d = 1'b1;
                        if (stage_match) begin
                            if (occ_q == count_q[stage_q]) begin
                                occ_d = '0;
                                if (stage_q == last_q) begin
                                    triggered_d = 1'b1;
                                    dout_trig_d = 1'b1;
                                    if (post_q == '0) begin
                                        dout_last_d = 1'b1;
                                        state_d     = ST_DONE;
                                    end else begin
                                        rem_d   = post_q;
                                        state_d = ST_POST;
                                    end
                                end else begin
                                    stage_d = stage_q + 1'b1;
                                end
                            end else begin
                                occ_d = occ_q + 1'b1;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (din_valid) begin
                        dout_d       = din;
                        dout_valid_d = 1'b1;
                        rem_d        = rem_q - 1'b1;
                        if (rem_q == saddr_w'(1)) begin
                            dout_last_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            stage_q      <= '0;
            last_q       <= '0;
            occ_q        <= '0;
            rem_q        <= '0;
            post_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_trig_q  <= 1'b0;
            dout_last_q  <= 1'b0;
            any_q        <= '0;
            for (int s = 0; s < num_stages; s++) begin
                mask_q[s]  <= '0;
                type_q[s]  <= '0;
                level_q[s] <= '0;
                count_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            last_q       <= last_d;
            occ_q        <= occ_d;
            rem_q        <= rem_d;
            post_q       <= post_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            triggered_q  <= triggered_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_trig_q  <= dout_trig_d;
            dout_last_q  <= dout_last_d;
            any_q        <= any_d;
            mask_q       <= mask_d;
            type_q       <= type_d;
            level_q      <= level_d;
            count_q      <= count_d;
        end
    end

    assign armed      = (state_q == ST_ARMED);
    assign done       = (state_q == ST_DONE);
    assign triggered  = triggered_q;
    assign stage      = stage_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_trig  = dout_trig_q;
    assign dout_last  = dout_last_q;

endmodule
